// File: rtl/snowbro2_gfx_arbiter.sv
// Four-channel GFX fetch arbiter with one-entry tag caches over one SDRAM bank.
// Define SNOWBRO2_GFX_ARB_PRIO_EN to give the sprite channel (ch0) fixed priority.
module snowbro2_gfx_arbiter #(
  parameter int          AW     = 21,
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [3:0]      CS,
  input  logic [4*AW-1:0] ADDR,
  output logic [3:0]      OK,
  output logic [127:0]    DOUT,
  output logic [21:0]     BA_ADDR,
  output logic            BA_RD,
  input  logic            BA_ACK,
  input  logic            BA_DOK,
  input  logic            BA_RDY,
  input  logic [15:0]     DATA_READ
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DATA,
    S_FILL
  } state_t;

  state_t          state_q;
  logic [3:0]      valid_q;
  logic [AW-1:0]   tag_q [4];
  logic [31:0]     data_q [4];
  logic [1:0]      last_q;
  logic [1:0]      gnt_q;
  logic [AW-1:0]   addr_q;
  logic [15:0]     lo_q;
  logic [15:0]     hi_q;
  logic [1:0]      dok_cnt_q;
  logic            rd_q;
  logic [21:0]     ba_addr_q;

  logic [3:0]      pend;
  logic [1:0]      gnt_d;
  logic [1:0]      idx;
  logic            found;
  logic [AW-1:0]   gaddr;

  for (genvar n = 0; n < 4; n++) begin : g_ch
    assign OK[n] = CS[n] & valid_q[n]
                 & (tag_q[n] == ADDR[n*AW +: AW]);
    assign DOUT[n*32 +: 32] = data_q[n];
  end

  assign pend    = CS & ~OK;
  assign BA_RD   = rd_q;
  assign BA_ADDR = ba_addr_q;

  // Search starts one past the last channel served, wrapping ch3 -> ch0.
  always_comb begin
    gnt_d = last_q;
    idx   = 2'd0;
    found = 1'b0;
`ifdef SNOWBRO2_GFX_ARB_PRIO_EN
    if (pend[0]) begin
      gnt_d = 2'd0;
      found = 1'b1;
    end else begin
      for (int i = 1; i <= 4; i++) begin
        idx = last_q + 2'(i);
        if (!found && idx != 2'd0 && pend[idx]) begin
          gnt_d = idx;
          found = 1'b1;
        end
      end
    end
`else
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && pend[idx]) begin
        gnt_d = idx;
        found = 1'b1;
      end
    end
`endif
    gaddr = ADDR[gnt_d*AW +: AW];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      valid_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      last_q    <= 2'd3;
      gnt_q     <= 2'd0;
      addr_q    <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      dok_cnt_q <= '0;
      rd_q      <= 1'b0;
      ba_addr_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (|pend) begin
            gnt_q     <= gnt_d;
            addr_q    <= gaddr;
            ba_addr_q <= OFFSET + 22'({gaddr, 1'b0});
            rd_q      <= 1'b1;
            dok_cnt_q <= 2'd0;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          if (BA_ACK) begin
            rd_q    <= 1'b0;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (BA_DOK) begin
            if (dok_cnt_q == 2'd0) begin
              lo_q      <= DATA_READ;
              dok_cnt_q <= 2'd1;
            end else if (dok_cnt_q == 2'd1) begin
              hi_q      <= DATA_READ;
              dok_cnt_q <= 2'd2;
            end
          end
          if (BA_RDY) state_q <= S_FILL;
        end
        S_FILL: begin
          tag_q[gnt_q]   <= addr_q;
          data_q[gnt_q]  <= {hi_q, lo_q};
          valid_q[gnt_q] <= 1'b1;
`ifdef SNOWBRO2_GFX_ARB_PRIO_EN
          if (gnt_q != 2'd0) last_q <= gnt_q;
`else
          last_q <= gnt_q;
`endif
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
